// File: rtl/n64_flashram_pkg.sv
// n64_flashram_pkg: opcodes, sequencer states and status-bit positions
// shared by the N64 FlashRAM command controller.
package n64_flashram_pkg;

    localparam logic [7:0] CMD_READ_ARRAY   = 8'hF0;
    localparam logic [7:0] CMD_STATUS       = 8'hE1;
    localparam logic [7:0] CMD_ERASE_SECTOR = 8'h4B;
    localparam logic [7:0] CMD_ERASE_CHIP   = 8'h3C;
    localparam logic [7:0] CMD_WRITE_MODE   = 8'hB4;
    localparam logic [7:0] CMD_WRITE_PAGE   = 8'hA5;
    localparam logic [7:0] CMD_EXECUTE      = 8'hD2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERASE_ARMED,
        ST_WRITE_LOAD,
        ST_BUSY
    } e_state;

    localparam int STAT_ERASE_BUSY = 0;
    localparam int STAT_WRITE_BUSY = 1;
    localparam int STAT_ERASE_DONE = 2;
    localparam int STAT_WRITE_DONE = 3;
    localparam int STAT_ILLEGAL    = 4;
    localparam int STAT_TIMEOUT    = 5;

endpackage

// File: rtl/n64_flashram_page_buffer.sv
// n64_flashram_page_buffer: 32x32 page buffer with independent halfword
// write enables and a registered CPU read port (read-before-write).
module n64_flashram_page_buffer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_we_hi,
    input  logic        i_we_lo,
    input  logic [4:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic [4:0]  i_raddr,
    output logic [31:0] o_rdata
);

    logic [31:0] r_mem [0:31];

    always_ff @(posedge clk) begin
        if (i_we_hi) r_mem[i_waddr][31:16] <= i_wdata;
        if (i_we_lo) r_mem[i_waddr][15:0]  <= i_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) o_rdata <= '0;
        else          o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/n64_flashram_ctrl.sv
// n64_flashram_ctrl: FlashRAM command sequencer between the N64 PI and the CPU.
// Define FLASHRAM_TIMEOUT_EN to force completion after TIMEOUT_CYCLES in BUSY.
module n64_flashram_ctrl
    import n64_flashram_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        n64_cmd_valid,
    input  logic [31:0] n64_cmd_data,
    input  logic        n64_buf_write,
    input  logic [5:0]  n64_buf_address,
    input  logic [15:0] n64_buf_wdata,
    output logic        n64_status_mode,
    output logic [7:0]  n64_status,
    input  logic [4:0]  cpu_address,
    output logic [31:0] cpu_rdata,
    output logic [9:0]  sector,
    output logic        operation_pending,
    output logic        write_or_erase,
    output logic        sector_or_all,
    input  logic        operation_done
);

    e_state      r_state;
    logic        r_status_mode;
    logic [5:0]  r_status;
    logic [9:0]  r_sector;
    logic        r_pending;
    logic        r_write_or_erase;
    logic        r_sector_or_all;

    logic [7:0]  w_opcode;
    logic [9:0]  w_offset;
    logic        w_done;
    logic        w_timeout;
    logic        w_finish;
    logic        w_arm_ok;
    logic        w_buf_we;
    logic        w_unused;
    e_state      w_state;

    assign w_opcode = n64_cmd_data[31:24];
    assign w_offset = n64_cmd_data[9:0];
    assign w_done   = (r_state == ST_BUSY) && operation_done;
    assign w_finish = w_done || w_timeout;
    // Commands arriving with a completion are decoded as if already back in IDLE.
    assign w_state  = w_finish ? ST_IDLE : r_state;
    assign w_arm_ok = (w_state != ST_BUSY);
    assign w_buf_we = n64_buf_write && (r_state == ST_WRITE_LOAD);

`ifdef FLASHRAM_TIMEOUT_EN
    logic [23:0] r_timeout_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                r_timeout_cnt <= '0;
        else if (r_state != ST_BUSY) r_timeout_cnt <= '0;
        else                         r_timeout_cnt <= r_timeout_cnt + 24'd1;
    end

    assign w_timeout = (r_state == ST_BUSY) && (r_timeout_cnt == TIMEOUT_CYCLES - 24'd1);
    assign w_unused  = ^n64_cmd_data[23:10];
`else
    assign w_timeout = 1'b0;
    assign w_unused  = ^{n64_cmd_data[23:10], TIMEOUT_CYCLES};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_status_mode    <= 1'b0;
            r_status         <= '0;
            r_sector         <= '0;
            r_pending        <= 1'b0;
            r_write_or_erase <= 1'b0;
            r_sector_or_all  <= 1'b0;
        end else begin
            if (w_finish) begin
                r_state                   <= ST_IDLE;
                r_pending                 <= 1'b0;
                r_status[STAT_ERASE_BUSY] <= 1'b0;
                r_status[STAT_WRITE_BUSY] <= 1'b0;
                if (w_done) begin
                    if (r_write_or_erase) r_status[STAT_ERASE_DONE] <= 1'b1;
                    else                  r_status[STAT_WRITE_DONE] <= 1'b1;
                end else begin
                    r_status[STAT_TIMEOUT] <= 1'b1;
                end
            end
            if (n64_cmd_valid) begin
                case (w_opcode)
                    CMD_READ_ARRAY: r_status_mode <= 1'b0;
                    CMD_STATUS:     r_status_mode <= 1'b1;
                    CMD_ERASE_SECTOR, CMD_ERASE_CHIP: begin
                        if (w_arm_ok) begin
                            r_sector_or_all  <= (w_opcode == CMD_ERASE_CHIP);
                            r_sector         <= (w_opcode == CMD_ERASE_CHIP) ? 10'd0 : {w_offset[9:7], 7'd0};
                            r_write_or_erase <= 1'b1;
                            r_status[STAT_TIMEOUT:STAT_ERASE_DONE] <= '0;
                            r_state          <= ST_ERASE_ARMED;
                        end else begin
                            r_status[STAT_ILLEGAL] <= 1'b1;
                        end
                    end
                    CMD_WRITE_MODE: begin
                        if (w_arm_ok) begin
                            r_status[STAT_TIMEOUT:STAT_ERASE_DONE] <= '0;
                            r_state <= ST_WRITE_LOAD;
                        end else begin
                            r_status[STAT_ILLEGAL] <= 1'b1;
                        end
                    end
                    CMD_EXECUTE: begin
                        if (w_state == ST_ERASE_ARMED) begin
                            r_pending                 <= 1'b1;
                            r_status[STAT_ERASE_BUSY] <= 1'b1;
                            r_state                   <= ST_BUSY;
                        end else begin
                            r_status[STAT_ILLEGAL] <= 1'b1;
                        end
                    end
                    CMD_WRITE_PAGE: begin
                        if (w_state == ST_WRITE_LOAD) begin
                            r_sector                  <= w_offset;
                            r_write_or_erase          <= 1'b0;
                            r_sector_or_all           <= 1'b0;
                            r_pending                 <= 1'b1;
                            r_status[STAT_WRITE_BUSY] <= 1'b1;
                            r_state                   <= ST_BUSY;
                        end else begin
                            r_status[STAT_ILLEGAL] <= 1'b1;
                        end
                    end
                    default: r_status[STAT_ILLEGAL] <= 1'b1;
                endcase
            end
        end
    end

    n64_flashram_page_buffer u_page_buffer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we_hi (w_buf_we && !n64_buf_address[0]),
        .i_we_lo (w_buf_we &&  n64_buf_address[0]),
        .i_waddr (n64_buf_address[5:1]),
        .i_wdata (n64_buf_wdata),
        .i_raddr (cpu_address),
        .o_rdata (cpu_rdata)
    );

    assign n64_status_mode   = r_status_mode;
    assign n64_status        = {2'b00, r_status};
    assign sector            = r_sector;
    assign operation_pending = r_pending;
    assign write_or_erase    = r_write_or_erase;
    assign sector_or_all     = r_sector_or_all;

endmodule

// File: tb/tb_n64_flashram_ctrl.sv
// tb_n64_flashram_ctrl: directed scenarios plus randomized command/buffer traffic
// compared every cycle against a behavioural FlashRAM model.
module tb_n64_flashram_ctrl;

    logic        clk;
    logic        reset_n;
    logic        n64_cmd_valid;
    logic [31:0] n64_cmd_data;
    logic        n64_buf_write;
    logic [5:0]  n64_buf_address;
    logic [15:0] n64_buf_wdata;
    logic        n64_status_mode;
    logic [7:0]  n64_status;
    logic [4:0]  cpu_address;
    logic [31:0] cpu_rdata;
    logic [9:0]  sector;
    logic        operation_pending;
    logic        write_or_erase;
    logic        sector_or_all;
    logic        operation_done;

    int totalChecks = 0;
    int badChecks   = 0;

    n64_flashram_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .n64_cmd_valid     (n64_cmd_valid),
        .n64_cmd_data      (n64_cmd_data),
        .n64_buf_write     (n64_buf_write),
        .n64_buf_address   (n64_buf_address),
        .n64_buf_wdata     (n64_buf_wdata),
        .n64_status_mode   (n64_status_mode),
        .n64_status        (n64_status),
        .cpu_address       (cpu_address),
        .cpu_rdata         (cpu_rdata),
        .sector            (sector),
        .operation_pending (operation_pending),
        .write_or_erase    (write_or_erase),
        .sector_or_all     (sector_or_all),
        .operation_done    (operation_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase of the device plus sticky flags and a halfword array.
    localparam int PH_IDLE  = 0;
    localparam int PH_ARMED = 1;
    localparam int PH_LOAD  = 2;
    localparam int PH_BUSY  = 3;

    int          mPhase;
    bit          mMode, mPending, mErase, mChip;
    bit          mEraseDone, mWriteDone, mIllegal;
    bit [9:0]    mSector;
    logic [15:0] mBuf [64];
    bit          mKnown [64];
    logic [31:0] mRdata;
    bit          mRdataValid;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = PH_IDLE;
        mMode = 0; mPending = 0; mErase = 0; mChip = 0;
        mEraseDone = 0; mWriteDone = 0; mIllegal = 0;
        mSector = '0;
        mRdata = '0;
        mRdataValid = 1;
        for (int i = 0; i < 64; i++) mKnown[i] = 0;
    endtask

    function automatic logic [7:0] modelStatus();
        bit busy;
        busy = (mPhase == PH_BUSY);
        return {3'b000, mIllegal, mWriteDone, mEraseDone, busy && !mErase, busy && mErase};
    endfunction

    task automatic modelStep(input logic cv, input logic [31:0] cd, input logic bw,
                             input logic [5:0] ba, input logic [15:0] bd,
                             input logic [4:0] ca, input logic od);
        logic [7:0] op;
        logic [9:0] off;
        bit         accepted;
        op  = cd[31:24];
        off = cd[9:0];
        accepted = bw && (mPhase == PH_LOAD);
        mRdata = {mBuf[2 * ca], mBuf[2 * ca + 1]};
        mRdataValid = mKnown[2 * ca] && mKnown[2 * ca + 1] && !(accepted && (ba / 2 == ca));
        if (accepted) begin
            mBuf[ba] = bd;
            mKnown[ba] = 1;
        end
        if (mPhase == PH_BUSY && od) begin
            mPending = 0;
            if (mErase) mEraseDone = 1; else mWriteDone = 1;
            mPhase = PH_IDLE;
        end
        if (cv) begin
            if (op == 8'hF0) mMode = 0;
            else if (op == 8'hE1) mMode = 1;
            else if (mPhase == PH_BUSY) mIllegal = 1;
            else if (op == 8'h4B || op == 8'h3C) begin
                mEraseDone = 0; mWriteDone = 0; mIllegal = 0;
                mErase = 1;
                mChip = (op == 8'h3C);
                mSector = mChip ? 10'd0 : (off & 10'h380);
                mPhase = PH_ARMED;
            end else if (op == 8'hB4) begin
                mEraseDone = 0; mWriteDone = 0; mIllegal = 0;
                mPhase = PH_LOAD;
            end else if (op == 8'hD2 && mPhase == PH_ARMED) begin
                mPending = 1;
                mPhase = PH_BUSY;
            end else if (op == 8'hA5 && mPhase == PH_LOAD) begin
                mSector = off; mErase = 0; mChip = 0;
                mPending = 1;
                mPhase = PH_BUSY;
            end else mIllegal = 1;
        end
    endtask

    // Drives one cycle of inputs, advances the model at the edge, and compares all outputs.
    task automatic applyStimulus(input logic cv, input logic [31:0] cd, input logic bw,
                                 input logic [5:0] ba, input logic [15:0] bd,
                                 input logic [4:0] ca, input logic od);
        n64_cmd_valid   = cv;
        n64_cmd_data    = cd;
        n64_buf_write   = bw;
        n64_buf_address = ba;
        n64_buf_wdata   = bd;
        cpu_address     = ca;
        operation_done  = od;
        @(posedge clk);
        modelStep(cv, cd, bw, ba, bd, ca, od);
        #1;
        checkOutput("status_mode", 32'(n64_status_mode), 32'(mMode));
        checkOutput("status", 32'(n64_status), 32'(modelStatus()));
        checkOutput("pending", 32'(operation_pending), 32'(mPending));
        checkOutput("sector", 32'(sector), 32'(mSector));
        checkOutput("write_or_erase", 32'(write_or_erase), 32'(mErase));
        checkOutput("sector_or_all", 32'(sector_or_all), 32'(mChip));
        if (mRdataValid) checkOutput("cpu_rdata", cpu_rdata, mRdata);
        @(negedge clk);
    endtask

    task automatic sendCmd(input logic [7:0] op, input logic [9:0] off, input logic od);
        applyStimulus(1'b1, {op, 14'd0, off}, 1'b0, 6'd0, 16'd0, 5'd0, od);
    endtask

    task automatic idleCycle(input logic od);
        applyStimulus(1'b0, 32'd0, 1'b0, 6'd0, 16'd0, 5'd0, od);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mode"}, 32'(n64_status_mode), 32'd0);
        checkOutput({tag, "_status"}, 32'(n64_status), 32'd0);
        checkOutput({tag, "_pending"}, 32'(operation_pending), 32'd0);
        checkOutput({tag, "_sector"}, 32'(sector), 32'd0);
        checkOutput({tag, "_woe"}, 32'(write_or_erase), 32'd0);
        checkOutput({tag, "_soa"}, 32'(sector_or_all), 32'd0);
        checkOutput({tag, "_rdata"}, cpu_rdata, 32'd0);
    endtask

    task automatic randomTraffic(input int cycles);
        logic [7:0] opTable [10];
        logic [7:0] op;
        logic       cv;
        opTable = '{8'hF0, 8'hE1, 8'h4B, 8'h3C, 8'hB4, 8'hD2, 8'hA5, 8'hD2, 8'hA5, 8'h00};
        for (int n = 0; n < cycles; n++) begin
            cv = ($urandom_range(0, 9) < 4);
            op = opTable[$urandom_range(0, 9)];
            if (op == 8'h00) op = 8'($urandom);
            applyStimulus(cv, {op, 14'($urandom), 10'($urandom)}, 1'($urandom),
                          6'($urandom), 16'($urandom), 5'($urandom),
                          ($urandom_range(0, 5) == 0));
        end
    endtask

    initial begin
        n64_cmd_valid = 0; n64_cmd_data = '0; n64_buf_write = 0;
        n64_buf_address = '0; n64_buf_wdata = '0; cpu_address = '0; operation_done = 0;
        reset_n = 1'b1;
        modelReset();
        #3 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkAllZero("reset");
        reset_n = 1'b1;

        sendCmd(8'hE1, 10'd0, 1'b0);
        checkOutput("e1_mode", 32'(n64_status_mode), 32'd1);
        checkOutput("e1_status", 32'(n64_status), 32'h00);

        sendCmd(8'hB4, 10'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd0, 16'hDEAD, 5'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd1, 16'hBEEF, 5'd0, 1'b0);
        for (int i = 2; i < 64; i++)
            applyStimulus(1'b0, 32'd0, 1'b1, 6'(i), 16'($urandom), 5'd0, 1'b0);
        sendCmd(8'hA5, 10'h155, 1'b0);
        checkOutput("prog_pending", 32'(operation_pending), 32'd1);
        checkOutput("prog_sector", 32'(sector), 32'h155);
        checkOutput("prog_woe", 32'(write_or_erase), 32'd0);
        checkOutput("prog_status", 32'(n64_status), 32'h02);
        idleCycle(1'b0);
        checkOutput("prog_rdata", cpu_rdata, 32'hDEADBEEF);
        idleCycle(1'b1);
        checkOutput("prog_done_pending", 32'(operation_pending), 32'd0);
        checkOutput("prog_done_status", 32'(n64_status), 32'h08);

        sendCmd(8'h4B, 10'h1FF, 1'b0);
        sendCmd(8'hD2, 10'd0, 1'b0);
        checkOutput("erase_sector", 32'(sector), 32'h180);
        checkOutput("erase_woe", 32'(write_or_erase), 32'd1);
        checkOutput("erase_soa", 32'(sector_or_all), 32'd0);
        checkOutput("erase_pending", 32'(operation_pending), 32'd1);
        idleCycle(1'b1);
        checkOutput("erase_done_status", 32'(n64_status), 32'h04);

        sendCmd(8'hD2, 10'd0, 1'b0);
        checkOutput("illegal_status", 32'(n64_status), 32'h14);
        checkOutput("illegal_pending", 32'(operation_pending), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd0, 16'h1234, 5'd0, 1'b0);
        idleCycle(1'b0);
        checkOutput("dropped_write_rdata", cpu_rdata, 32'hDEADBEEF);

        sendCmd(8'h4B, 10'd0, 1'b0);
        sendCmd(8'hD2, 10'd0, 1'b0);
        sendCmd(8'h3C, 10'h2AA, 1'b1);
        checkOutput("race_pending", 32'(operation_pending), 32'd0);
        checkOutput("race_soa", 32'(sector_or_all), 32'd1);
        checkOutput("race_status", 32'(n64_status), 32'h00);
        sendCmd(8'hD2, 10'd0, 1'b0);
        checkOutput("race_rearm_pending", 32'(operation_pending), 32'd1);
        idleCycle(1'b1);

        randomTraffic(800);

        sendCmd(8'hE1, 10'd0, 1'b0);
        idleCycle(1'b1);
        sendCmd(8'hB4, 10'd0, 1'b0);
        sendCmd(8'hA5, 10'h0F0, 1'b0);
        checkOutput("midbusy_pending", 32'(operation_pending), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkAllZero("midbusy_reset");
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
        idleCycle(1'b0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/n64_flashram_ctrl.md
Name: n64_flashram_ctrl

Overview:
Command sequencer for the emulated N64 FlashRAM save device. Decodes 32-bit command writes from the N64 PI side and collects page-buffer halfword writes into a 32x32-bit buffer. It raises an erase/program request towards the CPU, exposing sector, pending and type flags plus buffer read access. It tracks device status until the CPU firmware signals completion with a one-cycle done pulse.

Parameters:
TIMEOUT_CYCLES, 24'hFFFFFF, cycles BUSY may last before forced completion (only with FLASHRAM_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
n64_cmd_valid  in  1  one-cycle strobe, command word present
n64_cmd_data  in  32  [31:24] opcode, [9:0] page offset
n64_buf_write  in  1  one-cycle strobe, page-buffer halfword write
n64_buf_address  in  6  halfword index 0..63 within 128-byte page
n64_buf_wdata  in  16  halfword data, big-endian
n64_status_mode  out  1  1 = N64 reads return status, 0 = array data
n64_status  out  8  device status byte
cpu_address  in  5  page-buffer word index
cpu_rdata  out  32  page-buffer word, registered
sector  out  10  latched page/sector offset
operation_pending  out  1  operation awaiting CPU
write_or_erase  out  1  1 = erase, 0 = page program
sector_or_all  out  1  1 = whole-chip erase
operation_done  in  1  one-cycle CPU completion pulse

Behaviour:
- Reset (async assert, sync release): FSM IDLE, n64_status_mode=0, n64_status=0, sector=0, operation_pending=0, write_or_erase=0, sector_or_all=0, cpu_rdata=0. Buffer contents undefined.
- FSM states: IDLE, ERASE_ARMED, WRITE_LOAD, BUSY. All outputs registered; command at cycle N is visible at N+1.
- Opcodes, any state: 0xF0 -> status_mode=0; 0xE1 -> status_mode=1. Neither changes FSM state.
- 0x4B (IDLE/ERASE_ARMED/WRITE_LOAD): sector={offset[9:7],7'd0}, write_or_erase=1, sector_or_all=0 -> ERASE_ARMED.
- 0x3C (same states): sector=0, write_or_erase=1, sector_or_all=1 -> ERASE_ARMED.
- 0xB4 (same states): -> WRITE_LOAD. Buffer is not cleared.
- 0xD2 in ERASE_ARMED -> BUSY, operation_pending=1.
- 0xA5 in WRITE_LOAD: sector=offset, write_or_erase=0, sector_or_all=0 -> BUSY, operation_pending=1.
- Any other opcode, 0xD2/0xA5 in the wrong state, or any non-F0/E1 opcode in BUSY: ignored, status[4] illegal=1.
- Accepting 0x4B/0x3C/0xB4 clears status[5:2].
- Buffer writes accepted only in WRITE_LOAD. Word = addr[5:1]; addr[0]=0 writes bits [31:16], addr[0]=1 writes [15:0]. Writes in other states are silently dropped.
- cpu_rdata = buffer[cpu_address], one-cycle latency, readable in any state.
- status: [0] erase_busy, [1] write_busy (BUSY && matching type); [2] erase_done, [3] write_done; [4] illegal; [5] timeout; [7:6]=0.
- operation_done in BUSY: pending=0, done bit for the operation type set, -> IDLE. Ignored in other states.
- operation_done and n64_cmd_valid in the same cycle: completion applies first; the command is decoded against IDLE.
- Simultaneous buffer write and 0xA5: the buffer write lands before the FSM leaves WRITE_LOAD.
- sector and type flags hold their values after completion until the next arming command.

Optional Feature:
FLASHRAM_TIMEOUT_EN: a 24-bit counter runs while in BUSY. On reaching TIMEOUT_CYCLES: pending=0, status[5]=1, done bit not set, -> IDLE; the counter clears on BUSY entry. Without the macro there is no counter, status[5] is tied to 0, and BUSY waits indefinitely.

Decomposition:
- Package n64_flashram_pkg: opcode localparams (CMD_READ_ARRAY 8'hF0, CMD_STATUS 8'hE1, CMD_ERASE_SECTOR 8'h4B, CMD_ERASE_CHIP 8'h3C, CMD_WRITE_MODE 8'hB4, CMD_WRITE_PAGE 8'hA5, CMD_EXECUTE 8'hD2), e_state enum, status bit index constants.
- Sub-module n64_flashram_page_buffer: 32x32 dual-port RAM with 16-bit half-word write enables, registered read port.

Test Plan:
- Reset, then 0xE1 -> status_mode=1, status=8'h00, pending=0.
- 0xB4; write halfwords idx0=16'hDEAD, idx1=16'hBEEF; 0xA5 offset 10'h155 -> pending=1, sector=10'h155, write_or_erase=0, status[1]=1; cpu_address=0 -> cpu_rdata=32'hDEADBEEF next cycle; done pulse -> pending=0, status=8'h08.
- 0x4B offset 10'h1FF, then 0xD2 -> sector=10'h180, write_or_erase=1, sector_or_all=0, pending=1; done -> status=8'h04.
- 0xD2 from IDLE -> status[4]=1, pending stays 0; buffer write in IDLE -> readback unchanged.
- In BUSY, issue 0x3C and done in the same cycle -> completion, then ERASE_ARMED with sector_or_all=1, status[4]=0.
- With FLASHRAM_TIMEOUT_EN and TIMEOUT_CYCLES=16: program, no done -> pending falls after 16 cycles, status[5]=1; reset_n low mid-BUSY -> all outputs zero immediately.
